// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - programmable raster timing generator with frame-shadowed configuration
module video_timing_gen #(
  parameter int X_BITS = 13,
  parameter int Y_BITS = 13
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              ce,
  input  logic [X_BITS-1:0] h_active,
  input  logic [X_BITS-1:0] h_fp,
  input  logic [X_BITS-1:0] h_sync,
  input  logic [X_BITS-1:0] h_total,
  input  logic [Y_BITS-1:0] v_active,
  input  logic [Y_BITS-1:0] v_fp,
  input  logic [Y_BITS-1:0] v_sync,
  input  logic [Y_BITS-1:0] v_total,
  input  logic              hs_pol,
  input  logic              vs_pol,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              hn_out,
  output logic              vn_out,
  output logic              den_out,
  output logic [X_BITS-1:0] total_active_pix,
  output logic [Y_BITS-1:0] total_active_lines,
  output logic              frame_start,
  output logic [7:0]        frame_cnt,
  output logic              cfg_err
);

  // Two extra bits keep the porch/sync sums from overflowing the field width.
  localparam int XW = X_BITS + 2;
  localparam int YW = Y_BITS + 2;

  logic [X_BITS-1:0] sh_h_active;
  logic [X_BITS-1:0] sh_h_fp;
  logic [X_BITS-1:0] sh_h_sync;
  logic [X_BITS-1:0] sh_h_total;
  logic [Y_BITS-1:0] sh_v_active;
  logic [Y_BITS-1:0] sh_v_fp;
  logic [Y_BITS-1:0] sh_v_sync;
  logic [Y_BITS-1:0] sh_v_total;
  logic              sh_hs_pol;
  logic              sh_vs_pol;

  logic [X_BITS-1:0] hc;
  logic [Y_BITS-1:0] vc;

  logic [XW-1:0] h_sync_start;
  logic [XW-1:0] h_sync_end;
  logic [YW-1:0] v_sync_start;
  logic [YW-1:0] v_sync_end;
  logic          h_last;
  logic          v_last;
  logic          frame_wrap;
  logic          shadow_load;
  logic          hsync;
  logic          vsync;
  logic          den;

  assign h_sync_start = XW'(sh_h_active) + XW'(sh_h_fp);
  assign h_sync_end   = h_sync_start + XW'(sh_h_sync);
  assign v_sync_start = YW'(sh_v_active) + YW'(sh_v_fp);
  assign v_sync_end   = v_sync_start + YW'(sh_v_sync);

  // The shadowed geometry is only trusted when every region fits in its total.
  assign cfg_err = (sh_h_active == '0) || (sh_v_active == '0) ||
                   (h_sync_end > XW'(sh_h_total)) || (v_sync_end > YW'(sh_v_total));

  assign h_last      = (hc == sh_h_total - X_BITS'(1));
  assign v_last      = (vc == sh_v_total - Y_BITS'(1));
  assign frame_wrap  = ce && !cfg_err && h_last && v_last;
  // While illegal, keep resampling the inputs so a fix takes effect immediately.
  assign shadow_load = reset || (ce && cfg_err) || frame_wrap;

  // A zero sync width makes start == end, so the window is empty and no pulse is produced.
  assign hsync = (XW'(hc) >= h_sync_start) && (XW'(hc) < h_sync_end);
  assign vsync = (YW'(vc) >= v_sync_start) && (YW'(vc) < v_sync_end);
  assign den   = (hc < sh_h_active) && (vc < sh_v_active);

  assign total_active_pix   = sh_h_active;
  assign total_active_lines = sh_v_active;

  // Capture the timing configuration at reset, at each frame wrap, and while illegal.
  always_ff @(posedge clk_in) begin
    if (shadow_load) begin
      sh_h_active <= h_active;
      sh_h_fp     <= h_fp;
      sh_h_sync   <= h_sync;
      sh_h_total  <= h_total;
      sh_v_active <= v_active;
      sh_v_fp     <= v_fp;
      sh_v_sync   <= v_sync;
      sh_v_total  <= v_total;
      sh_hs_pol   <= hs_pol;
      sh_vs_pol   <= vs_pol;
    end
  end

  // Raster position counters; parked at the origin while the configuration is illegal.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (ce) begin
      if (cfg_err) begin
        hc <= '0;
        vc <= '0;
      end else if (h_last) begin
        hc <= '0;
        vc <= v_last ? '0 : vc + Y_BITS'(1);
      end else begin
        hc <= hc + X_BITS'(1);
      end
    end
  end

  // Registered outputs describe the pixel the counters pointed at before this ce edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      den_out     <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
      hn_out      <= ~hs_pol;
      vn_out      <= ~vs_pol;
    end else if (ce) begin
      if (cfg_err) begin
        x           <= '0;
        y           <= '0;
        den_out     <= 1'b0;
        frame_start <= 1'b0;
        hn_out      <= ~sh_hs_pol;
        vn_out      <= ~sh_vs_pol;
      end else begin
        x           <= hc;
        y           <= vc;
        den_out     <= den;
        frame_start <= (hc == '0) && (vc == '0);
        hn_out      <= hsync ~^ sh_hs_pol;
        vn_out      <= vsync ~^ sh_vs_pol;
        if (h_last && v_last) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen
module tb_video_timing_gen;

  localparam int XB = 13;
  localparam int YB = 13;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          ce;
  logic [XB-1:0] h_active, h_fp, h_sync, h_total;
  logic [YB-1:0] v_active, v_fp, v_sync, v_total;
  logic          hs_pol, vs_pol;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic          hn_out, vn_out, den_out;
  logic [XB-1:0] total_active_pix;
  logic [YB-1:0] total_active_lines;
  logic          frame_start;
  logic [7:0]    frame_cnt;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int ha, hf, hs, ht, va, vf, vs, vt;
    bit hp, vp;
  } cfg_t;

  // Reference model: frame position kept as a linear pixel index.
  cfg_t m_cfg;
  int   pix;
  int   e_x, e_y, e_fc;
  bit   e_den, e_hn, e_vn, e_fs;
  bit   chk_en = 1'b0;

  video_timing_gen #(.X_BITS(XB), .Y_BITS(YB)) dut (
    .clk_in(clk_in), .reset(reset), .ce(ce),
    .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_total(h_total),
    .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_total(v_total),
    .hs_pol(hs_pol), .vs_pol(vs_pol),
    .x(x), .y(y), .hn_out(hn_out), .vn_out(vn_out), .den_out(den_out),
    .total_active_pix(total_active_pix), .total_active_lines(total_active_lines),
    .frame_start(frame_start), .frame_cnt(frame_cnt), .cfg_err(cfg_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cfg_t sample_cfg();
    cfg_t c;
    c.ha = int'(h_active); c.hf = int'(h_fp); c.hs = int'(h_sync); c.ht = int'(h_total);
    c.va = int'(v_active); c.vf = int'(v_fp); c.vs = int'(v_sync); c.vt = int'(v_total);
    c.hp = hs_pol; c.vp = vs_pol;
    return c;
  endfunction

  function automatic bit illegal(input cfg_t c);
    return (c.ha == 0) || (c.va == 0) || (c.ha + c.hf + c.hs > c.ht) || (c.va + c.vf + c.vs > c.vt);
  endfunction

  task automatic model_step();
    int px, py;
    if (reset) begin
      m_cfg = sample_cfg();
      pix = 0;
      e_x = 0; e_y = 0; e_den = 0; e_fs = 0; e_fc = 0;
      e_hn = !hs_pol; e_vn = !vs_pol;
    end else if (ce) begin
      if (illegal(m_cfg)) begin
        e_x = 0; e_y = 0; e_den = 0; e_fs = 0;
        e_hn = !m_cfg.hp; e_vn = !m_cfg.vp;
        m_cfg = sample_cfg();
        pix = 0;
      end else begin
        px = pix % m_cfg.ht;
        py = pix / m_cfg.ht;
        e_x = px; e_y = py;
        e_den = (px < m_cfg.ha) && (py < m_cfg.va);
        e_hn = ((px >= m_cfg.ha + m_cfg.hf) && (px < m_cfg.ha + m_cfg.hf + m_cfg.hs)) == m_cfg.hp;
        e_vn = ((py >= m_cfg.va + m_cfg.vf) && (py < m_cfg.va + m_cfg.vf + m_cfg.vs)) == m_cfg.vp;
        e_fs = (pix == 0);
        pix++;
        if (pix == m_cfg.ht * m_cfg.vt) begin
          pix = 0;
          e_fc = (e_fc + 1) % 256;
          m_cfg = sample_cfg();
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("x", 32'(x), 32'(e_x));
    check("y", 32'(y), 32'(e_y));
    check("den_out", 32'(den_out), 32'(e_den));
    check("hn_out", 32'(hn_out), 32'(e_hn));
    check("vn_out", 32'(vn_out), 32'(e_vn));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("frame_cnt", 32'(frame_cnt), 32'(e_fc));
    check("total_active_pix", 32'(total_active_pix), 32'(m_cfg.ha));
    check("total_active_lines", 32'(total_active_lines), 32'(m_cfg.va));
    check("cfg_err", 32'(cfg_err), 32'(illegal(m_cfg)));
  endtask

  always @(posedge clk_in) model_step();

  always @(negedge clk_in) if (chk_en) compare_outputs();

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic wait_xy(input int tx, input int ty, input string name);
    int n = 0;
    while (!(int'(x) == tx && int'(y) == ty) && n < 2000) begin
      tick();
      n++;
    end
    check(name, 32'(int'(x) == tx && int'(y) == ty), 32'd1);
  endtask

  initial begin
    int den_n, hn_n, vn_n, fs_n, hx_min, hx_max, vy_min, vy_max;
    int n, xmax, rise_n;
    int rises[2];
    bit prev_fs;

    h_active = 8; h_fp = 2; h_sync = 3; h_total = 16;
    v_active = 4; v_fp = 1; v_sync = 2; v_total = 8;
    hs_pol = 1; vs_pol = 1;
    reset = 1; ce = 0;

    // Reset applies with ce low as well.
    tick();
    chk_en = 1;
    tick();
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_den", 32'(den_out), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_fc", 32'(frame_cnt), 0);
    check("rst_hn", 32'(hn_out), 0);
    check("rst_vn", 32'(vn_out), 0);
    check("rst_tap", 32'(total_active_pix), 8);
    check("rst_tal", 32'(total_active_lines), 4);
    check("rst_cfg_err", 32'(cfg_err), 0);

    reset = 0; ce = 1;
    tick();
    check("first_x", 32'(x), 0);
    check("first_y", 32'(y), 0);
    check("first_den", 32'(den_out), 1);
    check("first_fs", 32'(frame_start), 1);

    // One full frame of continuous ce: 16 x 8 = 128 cycles.
    den_n = 0; hn_n = 0; vn_n = 0; fs_n = 0;
    hx_min = 999; hx_max = -1; vy_min = 999; vy_max = -1;
    for (int i = 0; i < 128; i++) begin
      if (den_out) den_n++;
      if (frame_start) fs_n++;
      if (hn_out) begin
        hn_n++;
        if (int'(x) < hx_min) hx_min = int'(x);
        if (int'(x) > hx_max) hx_max = int'(x);
      end
      if (vn_out) begin
        vn_n++;
        if (int'(y) < vy_min) vy_min = int'(y);
        if (int'(y) > vy_max) vy_max = int'(y);
      end
      tick();
    end
    check("den_count", 32'(den_n), 32);
    check("hn_count", 32'(hn_n), 24);
    check("vn_count", 32'(vn_n), 32);
    check("fs_count", 32'(fs_n), 1);
    check("hn_x_min", 32'(hx_min), 10);
    check("hn_x_max", 32'(hx_max), 12);
    check("vn_y_min", 32'(vy_min), 5);
    check("vn_y_max", 32'(vy_max), 6);
    check("period_128", 32'(frame_start), 1);

    // Half-rate ce doubles the frame period in clocks.
    rise_n = 0; prev_fs = frame_start; rises[0] = 0; rises[1] = 0;
    for (int i = 1; i <= 600; i++) begin
      ce = (i % 2 == 1);
      tick();
      if (frame_start && !prev_fs) begin
        if (rise_n < 2) rises[rise_n] = i;
        rise_n++;
      end
      prev_fs = frame_start;
    end
    check("ce_rises", 32'(rise_n >= 2), 1);
    check("ce_period_256", 32'(rises[1] - rises[0]), 256);
    ce = 1;

    // Mid-frame geometry change is deferred to the frame wrap.
    wait_xy(5, 2, "reach_5_2");
    h_total = 20; h_active = 9;
    tick();
    check("tap_hold", 32'(total_active_pix), 8);
    n = 1; xmax = int'(x);
    while (!frame_start && n < 400) begin
      tick();
      n++;
      if (!frame_start && int'(x) > xmax) xmax = int'(x);
    end
    check("old_frame_len", 32'(n), 91);
    check("old_frame_xmax", 32'(xmax), 15);
    check("tap_new", 32'(total_active_pix), 9);
    n = 0; xmax = 0;
    do begin
      tick();
      n++;
      if (!frame_start && int'(x) > xmax) xmax = int'(x);
    end while (!frame_start && n < 400);
    check("new_frame_len", 32'(n), 160);
    check("new_frame_xmax", 32'(xmax), 19);

    // Illegal sync width: 8 + 2 + 10 > 16.
    h_total = 16; h_active = 8; h_sync = 10;
    n = 0;
    while (!cfg_err && n < 400) begin
      tick();
      n++;
    end
    check("err_rise_at_wrap", 32'(n), 159);
    tick();
    check("err_flag", 32'(cfg_err), 1);
    check("err_x", 32'(x), 0);
    check("err_y", 32'(y), 0);
    check("err_den", 32'(den_out), 0);
    check("err_hn", 32'(hn_out), 0);
    check("err_vn", 32'(vn_out), 0);
    check("err_fs", 32'(frame_start), 0);
    tick(); tick();
    check("err_hold_x", 32'(x), 0);
    check("err_hold_flag", 32'(cfg_err), 1);
    h_sync = 3;
    tick();
    check("fix_reload", 32'(cfg_err), 0);
    tick();
    check("fix_x", 32'(x), 0);
    check("fix_y", 32'(y), 0);
    check("fix_fs", 32'(frame_start), 1);
    check("fix_den", 32'(den_out), 1);

    // Reset mid-frame aborts it.
    wait_xy(7, 3, "reach_7_3");
    reset = 1;
    tick();
    check("mid_rst_x", 32'(x), 0);
    check("mid_rst_y", 32'(y), 0);
    check("mid_rst_den", 32'(den_out), 0);
    check("mid_rst_fs", 32'(frame_start), 0);
    check("mid_rst_fc", 32'(frame_cnt), 0);
    check("mid_rst_hn", 32'(hn_out), 0);
    reset = 0;
    tick();
    check("post_rst_x", 32'(x), 0);
    check("post_rst_y", 32'(y), 0);
    check("post_rst_fs", 32'(frame_start), 1);
    check("post_rst_den", 32'(den_out), 1);

    // 256 frames bring frame_cnt back to zero.
    repeat (127 + 128 * 254) tick();
    check("fc_255", 32'(frame_cnt), 255);
    repeat (128) tick();
    check("fc_wrap_0", 32'(frame_cnt), 0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Parameters
REQ-001 The block SHALL have parameter X_BITS, default 13: width of horizontal counter and timing fields.
REQ-002 The block SHALL have parameter Y_BITS, default 13: width of vertical counter and timing fields.

Interface
REQ-003 The block SHALL have port clk_in, input, 1: the single clock; all logic is clocked on the rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port ce, input, 1: pixel clock enable; counters and outputs update only when ce=1.
REQ-006 The block SHALL have ports h_active, h_fp, h_sync, h_total, inputs, X_BITS each: pixels per active line, front porch, sync width, total line length.
REQ-007 The block SHALL have ports v_active, v_fp, v_sync, v_total, inputs, Y_BITS each: lines per active frame, front porch, sync width, total frame length.
REQ-008 The block SHALL have ports hs_pol and vs_pol, inputs, 1 each: sync polarity, 1 = active-high pulse.
REQ-009 The block SHALL have ports x and y, outputs, X_BITS and Y_BITS: current horizontal and vertical counter values.
REQ-010 The block SHALL have ports hn_out, vn_out and den_out, outputs, 1 each: horizontal sync, vertical sync and data enable.
REQ-011 The block SHALL have ports total_active_pix and total_active_lines, outputs, X_BITS and Y_BITS: shadowed h_active and v_active.
REQ-012 The block SHALL have port frame_start, output, 1: marks the pixel x=0, y=0.
REQ-013 The block SHALL have port frame_cnt, output, 8: frame counter.
REQ-014 The block SHALL have port cfg_err, output, 1: shadowed configuration is illegal.

Function
REQ-015 Shadowing: all eight timing inputs, hs_pol and vs_pol SHALL be captured into shadow registers during reset and on the ce-cycle in which hc=h_total-1 and vc=v_total-1 (frame wrap).
REQ-016 Shadowing: input changes at any other time SHALL have no effect until the next frame wrap.
REQ-017 Counters: hc SHALL advance 0..h_total-1 and wrap to 0.
REQ-018 Counters: vc SHALL increment on each hc wrap, advance 0..v_total-1 and wrap to 0.
REQ-019 Counters: hc and vc SHALL hold when ce=0.
REQ-020 Outputs: all outputs SHALL be registered and updated only on ce=1 cycles, reflecting the counter values before that cycle's increment; latency counter-to-output is 1 ce-cycle.
REQ-021 Outputs: x SHALL equal hc and y SHALL equal vc in both active and blanking periods.
REQ-022 Outputs: den_out SHALL be 1 iff hc<h_active and vc<v_active.
REQ-023 Outputs: hsync SHALL be asserted iff h_active+h_fp <= hc < h_active+h_fp+h_sync, and hn_out SHALL be hsync XNOR hs_pol.
REQ-024 Outputs: vsync SHALL be asserted iff v_active+v_fp <= vc < v_active+v_fp+v_sync, evaluated on the whole line, and vn_out SHALL be vsync XNOR vs_pol.
REQ-025 Outputs: frame_start SHALL be 1 for exactly one ce-cycle of output, the one with x=0 and y=0.
REQ-026 Outputs: frame_cnt SHALL increment by 1 at each frame wrap and wrap 255->0.
REQ-027 Legality: cfg_err SHALL be 1 when h_active=0, v_active=0, h_active+h_fp+h_sync > h_total, or v_active+v_fp+v_sync > v_total, using X_BITS+2 and Y_BITS+2 wide sums with no overflow.
REQ-028 Legality: while cfg_err=1, hc and vc SHALL be held at 0, den_out=0, sync outputs SHALL be at their inactive level, and frame_start=0.
REQ-029 Legality: while cfg_err=1, shadow registers SHALL reload every ce-cycle so a corrected configuration starts a frame from x=0, y=0 on the next ce.
REQ-030 Degenerate settings: h_fp=0 or h_sync=0, and likewise for vertical, SHALL be legal; sync width 0 gives no pulse.

Reset
REQ-031 While reset=1, regardless of ce: hc=vc=0, x=0, y=0, den_out=0, frame_start=0, frame_cnt=0.
REQ-032 While reset=1: hn_out=~hs_pol input and vn_out=~vs_pol input (inactive level).
REQ-033 While reset=1: shadows load from inputs; total_active_pix=h_active and total_active_lines=v_active one cycle after reset asserts.
REQ-034 Reset asserted mid-frame SHALL abort the frame; the first ce after deassertion outputs x=0, y=0, den_out=1, frame_start=1 when the config is legal.

Verification
REQ-035 Config H 8/2/3/16, V 4/1/2/8, pols=1, ce=1 continuously -> frame period 128 cycles.
REQ-036 Same config -> den_out high 8 of 16 per line on lines 0-3; hn_out high for x=10..12; vn_out high for y=5..6; frame_start once per 128.
REQ-037 ce toggling 1,0,1,0 -> outputs change only on ce=1 cycles; frame period 256 clocks.
REQ-038 Change h_total to 20 at x=5, y=2 -> current frame keeps a 16-pixel line; next frame 160 cycles; total_active_pix updates only at the wrap.
REQ-039 h_sync=10 with h_total=16 -> cfg_err=1, den_out=0, x=y=0; restore h_sync=3 -> next ce gives x=0, y=0, frame_start=1.
REQ-040 Reset at x=7, y=3 -> next cycle all outputs at reset values; frame_cnt=0; first post-reset frame starts at x=0, y=0.
REQ-041 Run 256 frames -> frame_cnt returns to 0.
